// File: rtl/packet_arbiter_if.sv
// packet_arbiter_if -- request/merged-stream bundle for packet_arbiter.
//   master : requester side (drives req_*, observes req_ready and the merged stream)
//   slave  : arbiter side (observes req_*, drives req_ready and the merged stream)
// Signals:
//   req_valid/req_sop/req_eop/req_bad [N_PORTS]  per-port word valid and framing
//   req_residual [2*N_PORTS]                     port p at bits [2p+1:2p]
//   req_data [N_PORTS*DATA_WIDTH]                port p at slice p
//   req_ready [N_PORTS]                          per-port accept
//   ovalid/osop/oeop/obad, oresidual, odata      merged stream, no backpressure
//   ogrant [N_PORTS]                             one-hot owner, zero when idle
//   odrop_count [16]                             saturating orphan-word count
interface packet_arbiter_if #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_PORTS-1:0]            req_valid;
  logic [N_PORTS-1:0]            req_sop;
  logic [N_PORTS-1:0]            req_eop;
  logic [N_PORTS-1:0]            req_bad;
  logic [2*N_PORTS-1:0]          req_residual;
  logic [N_PORTS*DATA_WIDTH-1:0] req_data;
  logic [N_PORTS-1:0]            req_ready;
  logic                          ovalid;
  logic                          osop;
  logic                          oeop;
  logic                          obad;
  logic [1:0]                    oresidual;
  logic [DATA_WIDTH-1:0]         odata;
  logic [N_PORTS-1:0]            ogrant;
  logic [15:0]                   odrop_count;

  modport master (
    output req_valid, req_sop, req_eop, req_bad, req_residual, req_data,
    input  req_ready, ovalid, osop, oeop, obad, oresidual, odata, ogrant, odrop_count
  );

  modport slave (
    input  req_valid, req_sop, req_eop, req_bad, req_residual, req_data,
    output req_ready, ovalid, osop, oeop, obad, oresidual, odata, ogrant, odrop_count
  );
endinterface

// File: rtl/packet_arbiter.sv
// packet_arbiter -- round-robin packet arbiter merging N_PORTS framed word
// streams into one registered stream for the translator.
// Ports:
//   iclk  sole clock
//   irst  asynchronous active-high reset
//   bus   packet_arbiter_if.slave (per-port requests in, merged stream out)
// Optional feature: define PKT_ARB_TIMEOUT_EN to abort a packet whose owner
// stalls for TIMEOUT_CYCLES consecutive cycles; the aborted packet is closed
// with a single oeop+obad word.
//
// state | meaning
// IDLE  | no owner; pick next sop round-robin, drop orphan words
// ARB   | grant registered, one dead cycle before accepting
// BUSY  | owner's words forwarded until eop
// ABORT | (timeout build only) emit closing bad word, then IDLE
module packet_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             iclk,
  input logic             irst,
  packet_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_PORTS);

  if ((N_PORTS < 2) || (N_PORTS > 8) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("packet_arbiter: illegal parameter value");
  end

`ifdef PKT_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ARB, BUSY, ABORT} state_t;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            go_abort;
`else
  typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;
`endif

  state_t               state_q, state_d;
  logic [N_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_q, rr_d, rr_next;
  logic                 first_q, first_d;
  logic [15:0]          drop_q, drop_d;
  logic [N_PORTS-1:0]   ready, orphan, eligible;
  logic                 accept, found;
  logic [IDX_W-1:0]     pick;
  int                   cand;
  logic [3:0]           n_orphan;
  logic [16:0]          drop_sum;

  logic                  sel_valid, sel_sop, sel_eop, sel_bad;
  logic [1:0]            sel_residual;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  ovalid_q, osop_q, oeop_q, obad_q;
  logic [1:0]            oresidual_q;
  logic [DATA_WIDTH-1:0] odata_q;

  always_comb begin
    sel_valid    = bus.req_valid[gidx_q];
    sel_sop      = bus.req_sop[gidx_q];
    sel_eop      = bus.req_eop[gidx_q];
    sel_bad      = bus.req_bad[gidx_q];
    sel_residual = bus.req_residual[2*int'(gidx_q) +: 2];
    sel_data     = bus.req_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rr_next = (int'(gidx_q) == N_PORTS-1) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    first_d  = first_q;
    ready    = '0;
    orphan   = '0;
    accept   = 1'b0;
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    eligible = bus.req_valid & bus.req_sop;
`ifdef PKT_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Words without sop have no packet to belong to: accept and discard.
        orphan = bus.req_valid & ~bus.req_sop;
        ready  = orphan;
        for (int i = 0; i < N_PORTS; i++) begin
          cand = int'(rr_q) + i;
          if (cand >= N_PORTS) cand = cand - N_PORTS;
          if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = IDX_W'(cand);
          end
        end
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          gidx_d        = pick;
          first_d       = 1'b1;
          state_d       = ARB;
        end
`ifdef PKT_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ARB: state_d = BUSY;
      BUSY: begin
        ready  = grant_q;
        accept = sel_valid;
        if (accept) begin
          first_d = 1'b0;
          if (sel_eop) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_next;
          end
        end
`ifdef PKT_ARB_TIMEOUT_EN
        if (accept) begin
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = ABORT;
        end
`endif
      end
`ifdef PKT_ARB_TIMEOUT_EN
      ABORT: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_d     = rr_next;
        to_cnt_d = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef PKT_ARB_TIMEOUT_EN
  assign go_abort = (state_q == BUSY) && (state_d == ABORT);
`endif

  always_comb begin
    n_orphan = '0;
    for (int i = 0; i < N_PORTS; i++) n_orphan = n_orphan + {3'b000, orphan[i]};
    drop_sum = {1'b0, drop_q} + {13'b0, n_orphan};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      first_q <= 1'b0;
      drop_q  <= '0;
`ifdef PKT_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      first_q <= first_d;
      drop_q  <= drop_d;
`ifdef PKT_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Payload holds between words; only the framing flags are cleared when idle.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ovalid_q    <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
      obad_q      <= 1'b0;
      oresidual_q <= '0;
      odata_q     <= '0;
    end else if (accept) begin
      ovalid_q    <= 1'b1;
      osop_q      <= sel_sop & first_q;
      oeop_q      <= sel_eop;
      obad_q      <= sel_bad;
      oresidual_q <= sel_residual;
      odata_q     <= sel_data;
`ifdef PKT_ARB_TIMEOUT_EN
    end else if (go_abort) begin
      ovalid_q    <= 1'b1;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b1;
      obad_q      <= 1'b1;
      oresidual_q <= '0;
      odata_q     <= '0;
`endif
    end else begin
      ovalid_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      obad_q   <= 1'b0;
    end
  end

  assign bus.req_ready   = irst ? '0 : ready;
  assign bus.ovalid      = ovalid_q;
  assign bus.osop        = osop_q;
  assign bus.oeop        = oeop_q;
  assign bus.obad        = obad_q;
  assign bus.oresidual   = oresidual_q;
  assign bus.odata       = odata_q;
  assign bus.ogrant      = grant_q;
  assign bus.odrop_count = drop_q;
endmodule

// File: tb/tb_packet_arbiter.sv
module tb_packet_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;

  logic iclk;
  logic irst;
  int   n_checks;
  int   n_pass;

  packet_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  packet_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_sop      = '0;
    bus.req_eop      = '0;
    bus.req_bad      = '0;
    bus.req_residual = '0;
    bus.req_data     = '0;
  endtask

  task automatic set_word(input int p, input logic v, input logic s, input logic e,
                          input logic b, input logic [1:0] r, input logic [31:0] d);
    bus.req_valid[p]          = v;
    bus.req_sop[p]            = s;
    bus.req_eop[p]            = e;
    bus.req_bad[p]            = b;
    bus.req_residual[2*p +: 2] = r;
    bus.req_data[p*DW +: DW]  = d;
  endtask

  int          widx [NP];
  logic [NP-1:0] fire;
  logic [31:0] sop_data [$];
  int          sop_cyc [$];
  logic [31:0] exp_order [5];
  int          waited;
  logic        seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // reset state, with an orphan word presented during reset
    irst = 1'b1;
    clear_inputs();
    set_word(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h11);
    tick();
    tick();
    check("rst_ready",  32'(bus.req_ready), 32'h0);
    check("rst_ovalid", 32'(bus.ovalid), 32'h0);
    check("rst_ogrant", 32'(bus.ogrant), 32'h0);
    check("rst_drop",   32'(bus.odrop_count), 32'h0);
    check("rst_odata",  32'(bus.odata), 32'h0);
    clear_inputs();
    tick();
    irst = 1'b0;

    // 3-word packet on port 2, later word carries a stray sop
    set_word(2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hA0);
    tick();
    check("p2_grant", 32'(bus.ogrant), 32'h4);
    check("p2_arb_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check("p2_busy_ready", 32'(bus.req_ready), 32'h4);
    check("p2_busy_ovalid", 32'(bus.ovalid), 32'h0);
    tick();
    check("p2_w1_valid", 32'(bus.ovalid), 32'h1);
    check("p2_w1_sop",   32'(bus.osop), 32'h1);
    check("p2_w1_data",  bus.odata, 32'hA0);
    set_word(2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'hB1);
    tick();
    check("p2_w2_valid", 32'(bus.ovalid), 32'h1);
    check("p2_w2_sop",   32'(bus.osop), 32'h0);
    check("p2_w2_data",  bus.odata, 32'hB1);
    set_word(2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'hC2);
    tick();
    clear_inputs();
    check("p2_w3_eop",   32'(bus.oeop), 32'h1);
    check("p2_w3_res",   32'(bus.oresidual), 32'h2);
    check("p2_w3_data",  bus.odata, 32'hC2);
    check("p2_released", 32'(bus.ogrant), 32'h0);
    tick();
    check("p2_after_ovalid", 32'(bus.ovalid), 32'h0);

    // 5 orphan words on port 1 while idle
    set_word(1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h55);
    #1;
    check("orph_ready", 32'(bus.req_ready), 32'h2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("orph_no_ovalid", 32'(bus.ovalid), 32'h0);
    end
    clear_inputs();
    check("orph_drop5", 32'(bus.odrop_count), 32'd5);
    check("orph_no_grant", 32'(bus.ogrant), 32'h0);

    // all ports with 2-word packets from reset: order 0,1,2,3,0
    irst = 1'b1;
    tick();
    check("rst2_drop", 32'(bus.odrop_count), 32'h0);
    irst = 1'b0;
    for (int p = 0; p < NP; p++) widx[p] = 0;
    for (int cyc = 0; cyc < 40 && sop_data.size() < 5; cyc++) begin
      for (int p = 0; p < NP; p++)
        set_word(p, 1'b1, widx[p] == 0, widx[p] == 1, 1'b0, 2'd0, 32'(p*16 + widx[p]));
      #1;
      fire = bus.req_valid & bus.req_ready;
      tick();
      for (int p = 0; p < NP; p++) if (fire[p]) widx[p] = 1 - widx[p];
      if (bus.ovalid && bus.osop) begin
        sop_data.push_back(bus.odata);
        sop_cyc.push_back(cyc);
      end
    end
    clear_inputs();
    check("rr_pkt_count", 32'(sop_data.size()), 32'd5);
    exp_order[0] = 32'h00; exp_order[1] = 32'h10; exp_order[2] = 32'h20;
    exp_order[3] = 32'h30; exp_order[4] = 32'h00;
    if (sop_data.size() == 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), sop_data[k], exp_order[k]);
      for (int k = 0; k < 4; k++) check($sformatf("rr_spacing%0d", k), 32'(sop_cyc[k+1] - sop_cyc[k]), 32'd4);
    end

    // reset mid-packet on port 3, leftovers become orphans, port 0 then wins
    irst = 1'b1;
    tick();
    irst = 1'b0;
    set_word(3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h3A);
    tick();
    check("p3_grant", 32'(bus.ogrant), 32'h8);
    tick();
    tick();
    check("p3_w1_sop", 32'(bus.osop), 32'h1);
    check("p3_w1_data", bus.odata, 32'h3A);
    set_word(3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3B);
    #1;
    irst = 1'b1;
    #1;
    check("midrst_ovalid", 32'(bus.ovalid), 32'h0);
    check("midrst_ogrant", 32'(bus.ogrant), 32'h0);
    check("midrst_ready",  32'(bus.req_ready), 32'h0);
    check("midrst_odata",  bus.odata, 32'h0);
    check("midrst_oeop",   32'(bus.oeop), 32'h0);
    tick();
    irst = 1'b0;
    #1;
    check("p3_orphan_ready", 32'(bus.req_ready), 32'h8);
    tick();
    set_word(3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h3C);
    tick();
    clear_inputs();
    check("p3_drop2", 32'(bus.odrop_count), 32'd2);
    check("p3_no_ovalid", 32'(bus.ovalid), 32'h0);
    set_word(0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0D);
    tick();
    check("p0_grant", 32'(bus.ogrant), 32'h1);
    tick();
    tick();
    clear_inputs();
    check("p0_single_sop",  32'(bus.osop), 32'h1);
    check("p0_single_eop",  32'(bus.oeop), 32'h1);
    check("p0_single_data", bus.odata, 32'h0D);
    check("p0_single_res",  32'(bus.oresidual), 32'h3);
    check("p0_single_rel",  32'(bus.ogrant), 32'h0);

`ifdef PKT_ARB_TIMEOUT_EN
    // port 0 stalls after sop: abort after 64 stalled cycles
    irst = 1'b1;
    tick();
    irst = 1'b0;
    set_word(0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h77);
    tick();
    tick();
    tick();
    clear_inputs();
    check("to_sop", 32'(bus.osop), 32'h1);
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      waited++;
      if (bus.ovalid) seen = 1'b1;
    end
    check("to_seen", 32'(seen), 32'h1);
    check("to_cycles", 32'(waited), 32'd64);
    check("to_eop",   32'(bus.oeop), 32'h1);
    check("to_bad",   32'(bus.obad), 32'h1);
    check("to_data",  bus.odata, 32'h0);
    check("to_res",   32'(bus.oresidual), 32'h0);
    tick();
    check("to_idle_grant", 32'(bus.ogrant), 32'h0);
    set_word(0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h78);
    tick();
    set_word(0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h79);
    tick();
    clear_inputs();
    check("to_late_drop", 32'(bus.odrop_count), 32'd2);
    check("to_late_no_ovalid", 32'(bus.ovalid), 32'h0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4, number of requesters, legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32, word width, equal to the translator input width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, mid-packet stall limit; used only when PKT_ARB_TIMEOUT_EN is defined.
REQ-004 iclk  in  1  sole clock.
REQ-005 irst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_PORTS  per-port word valid.
REQ-007 req_sop / req_eop / req_bad  in  N_PORTS each  per-port framing flags.
REQ-008 req_residual  in  2*N_PORTS  per-port residual; port p occupies bits [2p+1:2p].
REQ-009 req_data  in  N_PORTS*DATA_WIDTH  per-port data; port p occupies slice p.
REQ-010 req_ready  out  N_PORTS  per-port accept; a word transfers when req_valid[p] and req_ready[p] are both high.
REQ-011 ovalid, osop, oeop, obad  out  1 each  merged stream to the translator; no backpressure.
REQ-012 oresidual  out  2, odata  out  DATA_WIDTH  merged stream payload.
REQ-013 ogrant  out  N_PORTS  one-hot current owner; all zero when idle.
REQ-014 odrop_count  out  16  saturating count of discarded orphan words.

Function
REQ-015 The block SHALL implement the states IDLE, ARB and BUSY; the ABORT state SHALL exist only when PKT_ARB_TIMEOUT_EN is defined.
REQ-016 In IDLE, eligible ports SHALL be those with req_valid & req_sop; if any are eligible, the block SHALL select one round-robin starting at rr_ptr, register the one-hot grant, and enter ARB.
REQ-017 In IDLE, any port with req_valid & ~req_sop SHALL get req_ready=1, its word SHALL be discarded, and odrop_count SHALL increment by one per discarded word, saturating at 0xFFFF.
REQ-018 ARB SHALL last exactly one cycle, SHALL assert no req_ready, and SHALL then enter BUSY.
REQ-019 In BUSY, req_ready SHALL equal ogrant; all other ports SHALL see req_ready=0.
REQ-020 Every accepted word SHALL appear on the output exactly 1 cycle later (registered outputs), with ovalid=1 and data/sop/eop/residual/bad copied unchanged.
REQ-021 osop SHALL be 1 only on the first word of a grant; a req_sop on any later word SHALL be forwarded as osop=0.
REQ-022 On an accepted word with req_eop=1, the block SHALL return to IDLE, clear ogrant, and set rr_ptr to (granted index + 1) mod N_PORTS.
REQ-023 The minimum gap between packets SHALL be 2 idle output cycles (IDLE + ARB); back-to-back words within a packet SHALL have no gap.
REQ-024 A single-word packet (sop & eop together) SHALL be forwarded with osop=oeop=1 and release the grant that cycle.
REQ-025 ovalid SHALL be 0 in every cycle in which no word was accepted in the previous cycle.
REQ-026 With all ports requesting continuously, grants SHALL rotate 0,1,2,...,N_PORTS-1,0.

Reset
REQ-027 While irst=1, the block SHALL be in IDLE with rr_ptr=0, ogrant=0, req_ready=0, ovalid=osop=oeop=obad=0, oresidual=0, odata=0, odrop_count=0, and the timeout counter=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately with no eop emitted; after release the port's remaining words SHALL be treated as orphans per REQ-017.

Configuration
REQ-029 When PKT_ARB_TIMEOUT_EN is defined, a counter SHALL count consecutive BUSY cycles with the granted req_valid=0 and SHALL clear on any accepted word.
REQ-030 When that counter reaches TIMEOUT_CYCLES, the block SHALL enter ABORT for one cycle and SHALL emit ovalid=1, oeop=1, obad=1, odata=0, oresidual=0.
REQ-031 After the ABORT cycle, the block SHALL enter IDLE with rr_ptr advanced per REQ-022; late words from the aborted port SHALL be dropped per REQ-017.
REQ-032 When PKT_ARB_TIMEOUT_EN is undefined, BUSY SHALL wait indefinitely and no ABORT logic SHALL be present.

Verification
REQ-033 Port 2 sends a 3-word packet, sop first and eop with residual 2 -> ogrant=0100; output shows 3 consecutive words 1 cycle after acceptance, osop on word 1, oeop and oresidual=2 on word 3.
REQ-034 All 4 ports hold 2-word packets continuously from reset -> output packet order is 0,1,2,3,0, with a 2-cycle gap between packets.
REQ-035 Port 1 presents 5 words without sop while idle -> all 5 accepted, no ovalid, odrop_count=5.
REQ-036 With PKT_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=64, port 0 stalls 64 cycles after sop -> one output word with oeop=1 and obad=1; port 0's 2 late words dropped; odrop_count=2.
REQ-037 irst pulsed mid-packet on port 3 -> all outputs 0 during reset; after release, port 3's remaining words are dropped and a new sop on port 0 is granted.
